led_pattern: RTL and testbench

Parametrised LED pattern generator for the board LED bank: a prescaler divides `clk` down to a programmable step rate, and on each step the output pattern advances according to a selectable mode: rotate right, rotate left, bounce, or bar fill. It is the general-purpose successor to the fixed 8-bit rotating-dot driver. It sits directly between the top-level clock/reset and the LED pins, and also exports a step pulse for other display logic.

---
 rtl/led_pkg.sv | 28 ++
 rtl/led_tick_gen.sv | 34 +++
 rtl/led_pattern.sv | 108 ++++++++++
 tb/tb_led_pattern.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    ROT_R  = 2'd0,
    ROT_L  = 2'd1,
    BOUNCE = 2'd2,
    FILL   = 2'd3
  } led_mode_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Widest LED bank the seed helper can describe; callers truncate to their width.
  localparam int unsigned SEED_MAX_W = 1024;

  function automatic logic [SEED_MAX_W-1:0] led_seed(input led_mode_t m, input int unsigned w);
    logic [SEED_MAX_W-1:0] v;
    v = '0;
    case (m)
      ROT_R, BOUNCE: v = SEED_MAX_W'(1) << (w - 1);
      ROT_L:         v = SEED_MAX_W'(1);
      default:       v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: counts clk cycles and flags a step every max(period,1) cycles.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             pause,
  input  logic [CNT_W-1:0] period,
  output logic             step
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_limit;

  // A period of 0 behaves like 1; >= lets a lowered period fire immediately.
  assign w_limit = (period == '0) ? '0 : period - CNT_W'(1);
  assign step    = !clr && !pause && (r_count >= w_limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (pause) begin
      r_count <= r_count;
    end else if (step) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern.sv
// LED pattern generator: rotate right/left, bounce or bar fill at a prescaled step rate.
module led_pattern
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic             pause,
  output logic [WIDTH-1:0] dataOut,
  output logic             tick,
  output logic             dir
);

  led_mode_t        w_mode;
  led_mode_t        r_mode_q;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic             r_tick;

  logic             w_restart;
  logic             w_step;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_nxt_data;
  logic             w_nxt_dir;
  logic             w_nxt_tick;
  led_mode_t        w_nxt_mode;

  assign w_mode    = led_mode_t'(mode);
  assign w_restart = (w_mode != r_mode_q);
  assign w_seed    = WIDTH'(led_seed(w_mode, WIDTH));

  led_tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_restart),
    .pause  (pause),
    .period (period),
    .step   (w_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= w_seed;
      r_mode_q <= w_mode;
      r_dir    <= DIR_DOWN;
      r_tick   <= 1'b0;
    end else begin
      r_data   <= w_nxt_data;
      r_mode_q <= w_nxt_mode;
      r_dir    <= w_nxt_dir;
      r_tick   <= w_nxt_tick;
    end
  end

  // Next-state: a mode restart beats any pending step; pause is folded into w_step.
  always_comb begin
    w_nxt_data = r_data;
    w_nxt_dir  = r_dir;
    w_nxt_tick = 1'b0;
    w_nxt_mode = r_mode_q;
    if (w_restart) begin
      w_nxt_data = w_seed;
      w_nxt_dir  = DIR_DOWN;
      w_nxt_mode = w_mode;
    end else if (w_step) begin
      w_nxt_tick = 1'b1;
      case (r_mode_q)
        ROT_R: w_nxt_data = {r_data[0], r_data[WIDTH-1:1]};
        ROT_L: w_nxt_data = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        BOUNCE: begin
          // Reverse on reaching an end so the end LED is not shown twice.
          if (r_dir == DIR_DOWN) begin
            if (r_data[0]) begin
              w_nxt_dir  = DIR_UP;
              w_nxt_data = r_data << 1;
            end else begin
              w_nxt_data = r_data >> 1;
            end
          end else begin
            if (r_data[WIDTH-1]) begin
              w_nxt_dir  = DIR_DOWN;
              w_nxt_data = r_data >> 1;
            end else begin
              w_nxt_data = r_data << 1;
            end
          end
        end
        FILL: w_nxt_data = (&r_data) ? '0 : {1'b1, r_data[WIDTH-1:1]};
        default: w_nxt_data = r_data;
      endcase
    end
  end

  // Outputs straight from registers.
  always_comb begin
    dataOut = r_data;
    tick    = r_tick;
    dir     = r_dir;
  end

endmodule

// File: tb/tb_led_pattern.sv
// Directed self-checking bench for led_pattern with WIDTH = 8.
module tb_led_pattern;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 22;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic [CNT_W-1:0] period;
  logic             pause;
  logic [WIDTH-1:0] dataOut;
  logic             tick;
  logic             dir;

  int n_checks;
  int n_errors;
  logic [7:0] cur_d;
  logic       cur_dir;

  led_pattern #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .period  (period),
    .pause   (pause),
    .dataOut (dataOut),
    .tick    (tick),
    .dir     (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] d, input logic t, input logic dr);
    check({tag, ".data"}, 32'(dataOut), 32'(d));
    check({tag, ".tick"}, 32'(tick), 32'(t));
    check({tag, ".dir"}, 32'(dir), 32'(dr));
  endtask

  // p-1 edges holding the current pattern, then one edge showing the new one with tick.
  task automatic step_expect(input string tag, input int p, input logic [7:0] d, input logic dr);
    for (int k = 0; k < p - 1; k++) begin
      cyc();
      check_state({tag, ".hold"}, cur_d, 1'b0, cur_dir);
    end
    cyc();
    check_state({tag, ".step"}, d, 1'b1, dr);
    cur_d   = d;
    cur_dir = dr;
  endtask

  logic [7:0] rotr_seq [8];
  logic [7:0] rotl_seq [8];
  logic [7:0] bnc_seq  [14];
  logic       bnc_dir  [14];
  logic [7:0] fill_seq [9];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rotr_seq = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    rotl_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    bnc_seq  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    bnc_dir  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    fill_seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};

    rst    = 1'b1;
    mode   = 2'd0;
    period = CNT_W'(4);
    pause  = 1'b0;
    cyc();
    cyc();
    check_state("reset", 8'h80, 1'b0, 1'b0);
    rst     = 1'b0;
    cur_d   = 8'h80;
    cur_dir = 1'b0;

    // ROT_R, period 4
    for (int i = 0; i < 8; i++) step_expect("rotr", 4, rotr_seq[i], 1'b0);

    // ROT_L, period 1: mode change restarts on the next edge
    mode   = 2'd1;
    period = CNT_W'(1);
    cyc();
    check_state("rotl.seed", 8'h01, 1'b0, 1'b0);
    cur_d = 8'h01;
    for (int i = 0; i < 8; i++) step_expect("rotl_p1", 1, rotl_seq[i], 1'b0);

    // ROT_L, period 0 behaves like period 1
    rst    = 1'b1;
    period = '0;
    cyc();
    check_state("rotl.reset", 8'h01, 1'b0, 1'b0);
    rst   = 1'b0;
    cur_d = 8'h01;
    for (int i = 0; i < 8; i++) step_expect("rotl_p0", 1, rotl_seq[i], 1'b0);

    // BOUNCE, period 2: full 14-step cycle then one more step down
    mode   = 2'd2;
    period = CNT_W'(2);
    cyc();
    check_state("bnc.seed", 8'h80, 1'b0, 1'b0);
    cur_d = 8'h80;
    for (int i = 0; i < 14; i++) step_expect("bnc", 2, bnc_seq[i], bnc_dir[i]);
    step_expect("bnc.wrap", 2, 8'h40, 1'b0);
    for (int i = 1; i < 8; i++) step_expect("bnc2", 2, bnc_seq[i], bnc_dir[i]);
    check("bnc.dir_up", 32'(dir), 32'(1));

    // Reset while bouncing upward
    rst = 1'b1;
    cyc();
    check_state("bnc.reset", 8'h80, 1'b0, 1'b0);
    rst     = 1'b0;
    cur_d   = 8'h80;
    cur_dir = 1'b0;

    // FILL, period 3
    mode   = 2'd3;
    period = CNT_W'(3);
    cyc();
    check_state("fill.seed", 8'h00, 1'b0, 1'b0);
    cur_d = 8'h00;
    for (int i = 0; i < 9; i++) step_expect("fill", 3, fill_seq[i], 1'b0);

    // Pause with the counter at 2
    mode   = 2'd0;
    period = CNT_W'(4);
    cyc();
    check_state("pause.seed", 8'h80, 1'b0, 1'b0);
    cur_d = 8'h80;
    cyc();
    cyc();
    check_state("pause.pre", 8'h80, 1'b0, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_state("pause.frozen", 8'h80, 1'b0, 1'b0);
    end
    pause = 1'b0;
    step_expect("pause.resume", 2, 8'h40, 1'b0);

    // Period raised to 100, lowered to 4 with the counter at 50
    period = CNT_W'(100);
    for (int i = 0; i < 50; i++) cyc();
    check_state("per100.hold", 8'h40, 1'b0, 1'b0);
    period = CNT_W'(4);
    step_expect("per.lower", 1, 8'h20, 1'b0);

    // Mode change ROT_R -> FILL at 0x10
    step_expect("pre_mc", 4, 8'h10, 1'b0);
    mode = 2'd3;
    cyc();
    check_state("mc.fill_seed", 8'h00, 1'b0, 1'b0);
    cur_d = 8'h00;
    step_expect("mc.fill_first", 4, 8'h80, 1'b0);

    // Mode change on the same edge as a pending step: restart wins, no tick
    cyc();
    cyc();
    cyc();
    check_state("mc2.pre", 8'h80, 1'b0, 1'b0);
    mode = 2'd0;
    cyc();
    check_state("mc2.restart", 8'h80, 1'b0, 1'b0);
    step_expect("mc2.first", 4, 8'h40, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
